// File: rtl/adder_tree_feeder.sv
// Double-buffered serial-to-parallel packer feeding the adder tree: words fill lanes
// in order, and the completed vector is presented registered and held until taken.
module adder_tree_feeder #(
  parameter int unsigned INPUTS_NUM  = 6,
  parameter int unsigned IDATA_WIDTH = 32,
  localparam int unsigned CNT_W      = $clog2(INPUTS_NUM + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [IDATA_WIDTH-1:0]            s_data,
  input  logic                              s_last,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [INPUTS_NUM*IDATA_WIDTH-1:0] m_data,
  output logic [CNT_W-1:0]                  m_count
);

  localparam int unsigned VecW = INPUTS_NUM * IDATA_WIDTH;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(INPUTS_NUM - 1);

  typedef enum logic [0:0] {StFill, StWait} state_e;

  state_e            state_q, state_d;
  logic [VecW-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [VecW-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              m_valid_q, m_valid_d;

  logic              s_hs, m_hs, complete;
  logic [VecW-1:0]   fill_wr;

  always_comb begin
    s_ready  = (state_q == StFill);
    s_hs     = s_valid && s_ready;
    m_hs     = m_valid_q && m_ready;
    complete = s_hs && (s_last || (idx_q == LastIdx));

    fill_wr = fill_q;
    for (int k = 0; k < int'(INPUTS_NUM); k++) begin
      if (idx_q == CNT_W'(k)) fill_wr[k*IDATA_WIDTH +: IDATA_WIDTH] = s_data;
    end

    state_d     = state_q;
    fill_d      = fill_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    m_valid_d   = m_valid_q;

    // Data/count are retained when the consumer drains with nothing to replace them.
    if (m_hs) m_valid_d = 1'b0;

    unique case (state_q)
      StFill: begin
        if (s_hs) begin
          if (complete && (!m_valid_q || m_ready)) begin
            out_data_d  = fill_wr;
            out_count_d = idx_q + CNT_W'(1);
            m_valid_d   = 1'b1;
            fill_d      = '0;
            idx_d       = '0;
          end else begin
            // In StWait idx_q holds the completed vector's word count.
            fill_d = fill_wr;
            idx_d  = idx_q + CNT_W'(1);
            if (complete) state_d = StWait;
          end
        end
      end
      StWait: begin
        if (m_hs) begin
          out_data_d  = fill_q;
          out_count_d = idx_q;
          m_valid_d   = 1'b1;
          fill_d      = '0;
          idx_d       = '0;
          state_d     = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      fill_q      <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      m_valid_q   <= m_valid_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = out_data_q;
  assign m_count = out_count_q;

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Scoreboard bench for adder_tree_feeder: a word-list model builds expected vectors,
// a negedge monitor pops and compares whenever a vector is taken.
module tb_adder_tree_feeder;

  localparam int N     = 6;
  localparam int W     = 32;
  localparam int CW    = $clog2(N + 1);
  localparam int VW    = N * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [VW-1:0] m_data;
  logic [CW-1:0] m_count;

  adder_tree_feeder #(.INPUTS_NUM(N), .IDATA_WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_count (m_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] data;
    int            count;
  } vec_t;

  vec_t         exp_q[$];
  logic [W-1:0] cur_words[$];
  int           n_checks = 0;
  int           n_pass = 0;
  bit           rand_mr = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Reference: a vector is the list of accepted words, closed by s_last or by reaching N.
  task automatic model_accept(input logic [W-1:0] word, input logic last);
    vec_t v;
    cur_words.push_back(word);
    if (last || cur_words.size() == N) begin
      v.data  = '0;
      v.count = cur_words.size();
      for (int i = 0; i < cur_words.size(); i++) v.data[i*W +: W] = cur_words[i];
      exp_q.push_back(v);
      cur_words.delete();
    end
  endtask

  // Called just after a posedge; returns just after the edge that accepted the word.
  task automatic send(input logic [W-1:0] word, input logic last);
    bit done = 1'b0;
    s_valid = 1'b1;
    s_data  = word;
    s_last  = last;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (s_ready) begin
        model_accept(word, last);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 256'(0), 256'(1));
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_empty", 256'(exp_q.size()), 256'(0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    cur_words.delete();
    #1;
    chk("rst_m_valid", 256'(m_valid), 256'(0));
    chk("rst_m_count", 256'(m_count), 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_s_ready", 256'(s_ready), 256'(1));
  endtask

  // Monitor: compare on every m-side handshake; verify data held while stalled.
  initial begin : monitor
    bit            stall = 1'b0;
    logic [VW-1:0] held_d;
    logic [CW-1:0] held_c;
    vec_t          e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall && m_valid) begin
          chk("stall_data", 256'(m_data), 256'(held_d));
          chk("stall_count", 256'(m_count), 256'(held_c));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_vector", 256'(1), 256'(0));
          end else begin
            e = exp_q.pop_front();
            chk("vec_data", 256'(m_data), 256'(e.data));
            chk("vec_count", 256'(m_count), 256'(e.count));
          end
        end
        stall  = m_valid && !m_ready;
        held_d = m_data;
        held_c = m_count;
      end
    end
  end

  initial begin : mready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rand_mr) m_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
    end
  end

  initial begin : stim
    int sum;
    #1;
    chk("reset_m_valid", 256'(m_valid), 256'(0));
    chk("reset_m_data", 256'(m_data), 256'(0));
    chk("reset_m_count", 256'(m_count), 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_s_ready", 256'(s_ready), 256'(1));

    // 1: full vector 1..6 back-to-back, latency and tree sum
    m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) send(W'(i), 1'b0);
    chk("lat_before", 256'(m_valid), 256'(0));
    send(W'(6), 1'b0);
    chk("lat_after", 256'(m_valid), 256'(1));
    sum = 0;
    for (int k = 0; k < N; k++) sum += int'(m_data[k*W +: W]);
    chk("tree_sum_21", 256'(sum), 256'(21));
    drain();

    // 2: short vector with s_last; 4: single-word vector
    send(W'(10), 1'b0);
    send(W'(20), 1'b0);
    send(W'(30), 1'b0);
    send(W'(40), 1'b1);
    chk("short_count", 256'(m_count), 256'(4));
    send(W'(7), 1'b1);
    chk("single_count", 256'(m_count), 256'(1));
    drain();

    // 3: stall with 13 words; B waits in fill buffer, 13th blocked
    m_ready = 1'b0;
    for (int i = 1; i <= 12; i++) send(W'(100 + i), 1'b0);
    chk("wait_s_ready", 256'(s_ready), 256'(0));
    chk("wait_m_valid", 256'(m_valid), 256'(1));
    chk("wait_held_a", 256'(m_data), 256'(exp_q[0].data));
    fork
      send(W'(113), 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
      end
    join
    chk("b_loaded", 256'(m_data), 256'(exp_q[0].data));
    m_ready = 1'b1;
    send(W'(114), 1'b1);
    drain();

    // 5: reset mid-fill, then a short vector must show no stale lanes
    for (int i = 1; i <= 3; i++) send(W'(50 + i), 1'b0);
    do_reset();
    m_ready = 1'b1;
    send(W'(61), 1'b0);
    send(W'(62), 1'b1);
    drain();
    // reset while in WAIT
    m_ready = 1'b0;
    for (int i = 1; i <= 12; i++) send(W'(200 + i), 1'b0);
    do_reset();
    m_ready = 1'b1;
    for (int i = 1; i <= 6; i++) send(W'(300 + i), 1'b0);
    drain();

    // 6: random vectors, random gaps and back-pressure
    rand_mr = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      int len;
      len = $urandom_range(1, N);
      for (int i = 0; i < len; i++) begin
        logic last;
        last = (i == len - 1) && (len < N || $urandom_range(0, 1) == 1);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
        send(W'($urandom), last);
      end
    end
    drain();
    rand_mr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
